// File: rtl/sw_debounce.sv
// Per-bit two-flop synchroniser and debounce counter with a registered change strobe.
// Macro SW_DEBOUNCE_EDGE_EN adds registered per-bit rise/fall pulses; otherwise they are tied to 0.
module sw_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic             sw_chg,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] r_sw_m;
  logic [WIDTH-1:0] r_sw_s;
  logic [WIDTH-1:0] r_sw_db;
  logic             r_chg;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_upd;

  assign w_diff = r_sw_s ^ r_sw_db;

  // A bit commits when it has disagreed with sw_db on DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_upd[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw_m  <= '0;
      r_sw_s  <= '0;
      r_sw_db <= '0;
      r_chg   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sw_m  <= sw;
      r_sw_s  <= r_sw_m;
      r_sw_db <= r_sw_db ^ w_upd;
      r_chg   <= |w_upd;
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_diff[i] || w_upd[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign sw_db  = r_sw_db;
  assign sw_chg = r_chg;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // The committed value is the synchronised bit, so it gives the edge direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_upd & r_sw_s;
      r_fall <= w_upd & ~r_sw_s;
    end
  end

  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (DEBOUNCE_CYCLES=4): directed test-plan phases plus random bouncing,
// every cycle compared against a sliding-window reference model.
module tb_sw_debounce;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw;
  logic [W-1:0] sw_db;
  logic         sw_chg;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pulse;

  sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .sw_db   (sw_db),
    .sw_chg  (sw_chg),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the synchronised value seen on each edge is kept in a window of the
  // last D edges; a bit commits when every entry in that window disagrees with sw_db.
  logic [W-1:0] m_m, m_s, m_db, m_rise, m_fall, m_upd;
  logic         m_chg;
  logic [W-1:0] hist[$];

  initial begin
    m_m = '0; m_s = '0; m_db = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_m = '0; m_s = '0; m_db = '0;
      m_chg = 1'b0; m_rise = '0; m_fall = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s);
      if (hist.size() > D) void'(hist.pop_front());
      m_upd = '0;
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          m_upd[b] = 1'b1;
          for (int j = 0; j < D; j++) begin
            if (hist[j][b] == m_db[b]) m_upd[b] = 1'b0;
          end
        end
      end
      m_chg  = |m_upd;
      m_rise = m_upd & ~m_db;
      m_fall = m_upd & m_db;
      m_db   = m_db ^ m_upd;
      m_s    = m_m;
      m_m    = sw;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, then compare all outputs against the model away from the clock edge.
  task automatic tick(input logic [W-1:0] v, input logic r);
    sw    = v;
    rst_n = r;
    @(posedge clk);
    @(negedge clk);
    chk("sw_db", int'(sw_db), int'(m_db));
    chk("sw_chg", int'(sw_chg), int'(m_chg));
`ifdef SW_DEBOUNCE_EDGE_EN
    chk("sw_rise", int'(sw_rise), int'(m_rise));
    chk("sw_fall", int'(sw_fall), int'(m_fall));
`else
    chk("sw_rise_off", int'(sw_rise), 0);
    chk("sw_fall_off", int'(sw_fall), 0);
`endif
    if (sw_chg) n_pulse++;
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    for (int k = 0; k < n; k++) tick(v, 1'b1);
  endtask

  // Count cycles until sw_db equals target, bounded.
  task automatic lat(input logic [W-1:0] v, input logic [W-1:0] target, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick(v, 1'b1);
      n++;
      if (sw_db == target) break;
    end
  endtask

  int n;
  int run, max_run;
  logic [W-1:0] v;

  initial begin
    sw = '0;
    rst_n = 1'b0;

    // 1. reset hold with switches high, then release
    n_pulse = 0;
    for (int k = 0; k < 5; k++) begin
      tick(4'b1111, 1'b0);
      chk("rst_db", int'(sw_db), 0);
      chk("rst_chg", int'(sw_chg), 0);
    end
    n_pulse = 0;
    lat(4'b1111, 4'b1111, n);
    chk("lat_release", n, D + 2);
    hold(4'b1111, 4);
    chk("pulses_release", n_pulse, 1);

    // 2. clean step from 0 to 0101
    hold(4'b0000, 10);
    chk("settle0", int'(sw_db), 0);
    n_pulse = 0;
    lat(4'b0101, 4'b0101, n);
    chk("lat_step", n, D + 2);
`ifdef SW_DEBOUNCE_EDGE_EN
    chk("step_rise", int'(sw_rise), 5);
    chk("step_fall", int'(sw_fall), 0);
`endif
    hold(4'b0101, 4);
    chk("pulses_step", n_pulse, 1);

    // 3. bounce on bit 0, then a short glitch that must be rejected
    hold(4'b0000, 10);
    n_pulse = 0;
    tick(4'b0001, 1'b1);
    tick(4'b0000, 1'b1);
    tick(4'b0001, 1'b1);
    tick(4'b0000, 1'b1);
    lat(4'b0001, 4'b0001, n);
    chk("lat_bounce", n, D + 2);
    hold(4'b0001, 6);
    chk("pulses_bounce", n_pulse, 1);
    hold(4'b0000, 10);
    n_pulse = 0;
    hold(4'b0001, D - 1);
    hold(4'b0000, 12);
    chk("glitch_db", int'(sw_db), 0);
    chk("pulses_glitch", n_pulse, 0);

    // 4. sweep all values
    n_pulse = 0;
    for (int i = 0; i < 16; i++) hold(W'(i), 10);
    chk("sweep_db", int'(sw_db), 15);
    chk("pulses_sweep", n_pulse, 15);

    // 5. reset mid-count discards progress
    hold(4'b0000, 10);
    hold(4'b1000, 3);
    tick(4'b1000, 1'b0);
    chk("midrst_db", int'(sw_db), 0);
    lat(4'b1000, 4'b1000, n);
    chk("lat_midrst", n, D + 2);

    // 6. staggered bits give back-to-back strobes
    hold(4'b0000, 10);
    n_pulse = 0;
    run = 0;
    max_run = 0;
    tick(4'b1000, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick(4'b1100, 1'b1);
      run = sw_chg ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("stagger_db", int'(sw_db), 12);
    chk("pulses_stagger", n_pulse, 2);
    chk("stagger_run", max_run, 2);

    // Random bouncing with occasional resets
    for (int k = 0; k < 400; k++) begin
      v = W'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        tick(v, 1'b0);
      end else begin
        hold(v, $urandom_range(1, 8));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Upstream conditioning stage for the board slide switches.
- Synchronises each raw, asynchronous `sw` bit into the clock domain and debounces it.
- Presents a stable `sw_db` bus that feeds the combinational `sw`→`led` logic stages.
- Also emits a one-cycle change strobe so later sequential stages can react to switch edits.

Parameters:
- WIDTH, 4, number of switch bits conditioned independently.
- DEBOUNCE_CYCLES, 16, consecutive clock cycles a synchronised bit must differ from `sw_db` before `sw_db` takes the new value. Minimum 2. The board build overrides this to roughly 10 ms of clocks.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- sw  input  WIDTH  raw switch levels, asynchronous, may bounce.
- sw_db  output  WIDTH  debounced, synchronised switch value.
- sw_chg  output  1  one-cycle pulse when any `sw_db` bit updates.
- sw_rise  output  WIDTH  per-bit 0→1 pulse (see Optional Feature).
- sw_fall  output  WIDTH  per-bit 1→0 pulse (see Optional Feature).

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is synchronous and active-low: sampled only on the rising edge of `clk`, takes effect when 0.
- Reset values:
  - sync flops `sw_m`, `sw_s` = 0
  - `sw_db` = 0
  - all per-bit counters = 0
  - `sw_chg`, `sw_rise`, `sw_fall` = 0
- Reset asserted mid-count discards all progress. No output change is carried through reset.
- Synchroniser: two flops per bit. `sw_m` <= `sw`; `sw_s` <= `sw_m`. Only `sw_s` is used downstream.
- Per-bit counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES)`. Each rising edge with `rst_n`=1:
  - if `sw_s[i]` == `sw_db[i]`: `cnt[i]` <= 0
  - else if `cnt[i]` == DEBOUNCE_CYCLES-1: `sw_db[i]` <= `sw_s[i]`, `cnt[i]` <= 0
  - else: `cnt[i]` <= `cnt[i]`+1
- Any single cycle of agreement restarts the count, so a bounce shorter than DEBOUNCE_CYCLES never reaches `sw_db`.
- Counter never wraps; it saturates by the rule above.
- Latency: `sw` changes before edge k and then stays stable → `sw_db` shows the new value after edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges including k.
- Bits are fully independent. Several bits may update on the same edge.
- `sw_chg`: registered. It is 1 for exactly the cycle following the edge on which any `sw_db` bit updated, aligned with the new `sw_db` value, and 0 otherwise.
  - Simultaneous multi-bit updates give a single pulse.
  - Updates on consecutive edges give `sw_chg` high on consecutive cycles.
- Switch held at 1 through reset release: `sw_db` rises to 1 DEBOUNCE_CYCLES+2 edges after the first edge with `rst_n`=1. `sw_chg` pulses once at that point.
- All outputs are registered; no combinational path from `sw` to any output.

Optional Feature:
- Macro: SW_DEBOUNCE_EDGE_EN.
- Defined: `sw_rise[i]` and `sw_fall[i]` are registered one-cycle pulses, aligned with `sw_chg`, marking `sw_db[i]` 0→1 and 1→0 transitions respectively. Reset value 0.
- Undefined: both ports remain on the interface, tied to constant 0, and no edge logic is synthesised. This keeps parent instantiations identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, 10 ns clock):
1. Reset hold, `sw`=4'b1111, `rst_n`=0 for 5 cycles → `sw_db`=0, `sw_chg`=0 throughout. After `rst_n`=1: `sw_db`=4'b1111 exactly 6 edges later; `sw_chg` high for 1 cycle.
2. Clean step: `sw` 0→4'b0101 stable → `sw_db`=4'b0101 after 6 edges; single `sw_chg` pulse. With SW_DEBOUNCE_EDGE_EN defined: `sw_rise`=4'b0101 for that cycle and `sw_fall`=0.
3. Bounce: `sw[0]` toggles 1,0,1,0 each cycle for 3 cycles, then held 1 → `sw_db[0]` changes only after 6 stable edges from the final transition; exactly one `sw_chg` pulse. A glitch of 3 cycles returning to 0 leaves `sw_db` unchanged and `sw_chg` at 0.
4. Sweep: drive `sw`=i for i=0..15, holding each value 10 cycles → `sw_db` follows each value with 6-edge latency; 15 `sw_chg` pulses; no intermediate values appear on `sw_db`.
5. Reset mid-count: `sw` 0→4'b1000, assert `rst_n`=0 after 3 cycles for 1 cycle, then release with `sw` held → `sw_db` stays 0 until 6 edges after release, then 4'b1000.
6. Staggered bits: `sw[3]` rises at cycle 0, `sw[2]` at cycle 1 → `sw_db[3]` and `sw_db[2]` update on consecutive edges; `sw_chg` is high for 2 consecutive cycles. With SW_DEBOUNCE_EDGE_EN undefined, `sw_rise` and `sw_fall` stay 0.
